ads1278_frame_reader: RTL and testbench
=======================================

Name: ads1278_frame_reader

Overview:
- Sequences ADS1278 acquisition for the 32x32 NIRS front end.
- Generates the ADC master clock, issues the SYNC pulse and waits for DRDY.
- Reads each frame in SPI frame-sync mode, shifting NUM_CH channels of DATA_W bits on SCLK.
- Delivers each channel word with a one-cycle valid pulse to the receive data-analysis path.

Parameters:
- CLK_DIV, 2: o_ads1278_clk half-period in sys_clk cycles. Must be ≥1.
- SCLK_DIV, 2: o_ads1278_sclk half-period in sys_clk cycles. Must be ≥1.
- NUM_CH, 8: channels per frame.
- DATA_W, 24: bits per channel, MSB first.
- SYNC_LEN, 4: o_ads1278_sync_n low width in sys_clk cycles.

Ports:
- sys_clk, input, 1: single system clock. All logic is on its rising edge.
- sys_rst_n, input, 1: asynchronous active-low reset.
- i_start, input, 1: level; high requests continuous acquisition.
- i_ads1278_drdy_n, input, 1: ADC data-ready, active low, asynchronous to sys_clk.
- i_ads1278_dout, input, 1: ADC serial data.
- o_ads1278_clk, output, 1: ADC master clock.
- o_ads1278_sclk, output, 1: serial clock. Idles low.
- o_ads1278_sync_n, output, 1: ADC SYNC, active low.
- o_ch_data, output, DATA_W: last completed channel word.
- o_ch_idx, output, $clog2(NUM_CH): channel index of o_ch_data.
- o_ch_valid, output, 1: one-cycle strobe qualifying o_ch_data and o_ch_idx.
- o_frame_done, output, 1: one-cycle strobe after the last channel of a frame.
- o_busy, output, 1: high in any state except IDLE.
- o_overrun, output, 1: sticky; DRDY fell during SHIFT.

Behaviour:
- Reset values: every output is 0, except o_ads1278_sync_n = 1. All counters and the shift register are 0 and the state is IDLE. Reset asserted mid-frame aborts the frame immediately; o_ads1278_sclk returns low in the same event.
- o_ads1278_clk toggles every CLK_DIV cycles whenever out of reset, independent of state.
- i_ads1278_drdy_n passes through a 2-FF synchronizer. A falling edge is detected on the synchronized signal, so drdy_fall lags the pin by 2–3 cycles.
- IDLE: when i_start = 1, go to SYNC.
- SYNC: o_ads1278_sync_n is held low for exactly SYNC_LEN cycles and o_overrun is cleared. Then go to WAIT_DRDY.
- WAIT_DRDY:
  - drdy_fall: go to SHIFT, with bit counter = 0 and channel counter = 0.
  - i_start = 0 (and no drdy_fall): go to IDLE.
- SHIFT:
  - SCLK phase counter runs 0..SCLK_DIV-1. o_ads1278_sclk rises at phase wrap from low and falls at the next wrap.
  - i_ads1278_dout is sampled into the shift register, MSB first, on the sys_clk cycle in which sclk goes 0→1.
  - After DATA_W samples: on the following cycle o_ch_data = assembled word, o_ch_idx = channel counter, and o_ch_valid = 1 for one cycle. The channel counter then increments.
  - After channel NUM_CH-1, sclk is held low and the state goes to DONE.
  - drdy_fall during SHIFT sets o_overrun = 1. The frame continues unchanged.
- DONE: o_frame_done = 1 for one cycle. Next state is WAIT_DRDY if i_start = 1, else IDLE.
- i_start deasserted during SHIFT: the current frame completes and emits all NUM_CH words, then DONE goes to IDLE.
- Timing per bit is 2*SCLK_DIV cycles. A frame spans NUM_CH*DATA_W*2*SCLK_DIV cycles from SHIFT entry to the last sample.
- o_ch_data holds its value between valid strobes. o_ch_valid and o_frame_done are never both high in the same cycle.

Test Plan:
- Reset/idle:
  - Stimulus: hold sys_rst_n = 0, then release with i_start = 0 for 100 cycles.
  - Required response: sclk = 0, sync_n = 1, busy = 0, no valid strobes. o_ads1278_clk has period 4 cycles (CLK_DIV = 2).
- Sync pulse:
  - Stimulus: raise i_start.
  - Required response: sync_n low for exactly 4 cycles starting 1 cycle after i_start is sampled. Then busy = 1 in WAIT_DRDY.
- Single frame (defaults):
  - Stimulus: drive drdy_n low. A DOUT model shifts channel k word = 0xA5_0000 + k on sclk falling edges.
  - Required response: 8 valid strobes with idx 0..7 and data 0xA50000..0xA50007. Strobes are 96 cycles apart. frame_done follows the idx 7 strobe. Total SHIFT length is 768 cycles.
- Stop mid-frame:
  - Stimulus: drop i_start after the channel-3 strobe.
  - Required response: channels 4–7 are still delivered, then frame_done, then IDLE with busy = 0. No further sclk edges.
- Overrun:
  - Stimulus: pulse drdy_n low again 200 cycles into SHIFT.
  - Required response: overrun = 1 and the frame data stays correct. Overrun clears on the next SYNC.
- Reset mid-frame:
  - Stimulus: assert sys_rst_n = 0 during channel 2.
  - Required response: all outputs return to reset values immediately. After release with i_start = 1, the block restarts from SYNC.

Source files
------------

// File: rtl/ads1278_frame_reader.sv
// ADS1278 acquisition sequencer: master clock, SYNC pulse, DRDY wait and
// frame-sync SPI readout of NUM_CH words of DATA_W bits, MSB first.
//
// Ports:
//   sys_clk, sys_rst_n        : system clock, async active-low reset
//   i_start                   : level, high requests continuous acquisition
//   i_ads1278_drdy_n          : ADC data-ready (async, active low)
//   i_ads1278_dout            : ADC serial data
//   o_ads1278_clk             : ADC master clock (toggles every CLK_DIV)
//   o_ads1278_sclk            : serial clock, idles low
//   o_ads1278_sync_n          : ADC SYNC, active low
//   o_ch_data/o_ch_idx        : last completed channel word and its index
//   o_ch_valid                : one-cycle strobe for o_ch_data/o_ch_idx
//   o_frame_done              : one-cycle strobe after the last channel
//   o_busy                    : high whenever not IDLE
//   o_overrun                 : sticky, DRDY fell during SHIFT
module ads1278_frame_reader #(
    parameter int CLK_DIV  = 2,
    parameter int SCLK_DIV = 2,
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 24,
    parameter int SYNC_LEN = 4,
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_start,
    input  logic              i_ads1278_drdy_n,
    input  logic              i_ads1278_dout,
    output logic              o_ads1278_clk,
    output logic              o_ads1278_sclk,
    output logic              o_ads1278_sync_n,
    output logic [DATA_W-1:0] o_ch_data,
    output logic [IW-1:0]     o_ch_idx,
    output logic              o_ch_valid,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     mclk_cnt;
    logic              mclk;
    logic              drdy_meta;
    logic              drdy_sync;
    logic              drdy_prev;
    logic              drdy_fall;
    logic [SW-1:0]     sync_cnt;
    logic [PW-1:0]     phase;
    logic [BW-1:0]     bit_cnt;
    logic [IW-1:0]     ch_cnt;
    logic [DATA_W-1:0] shreg;
    logic              word_rdy;
    logic              tail;
    logic              sclk;
    logic              sync_n;
    logic              phase_wrap;
    logic              sclk_rise;
    logic              sync_last;
    logic              word_last;
    logic              ch_last;

    assign o_ads1278_clk    = mclk;
    assign o_ads1278_sclk   = sclk;
    assign o_ads1278_sync_n = sync_n;
    assign o_busy           = (state != S_IDLE);

    // Free-running master clock, independent of the sequencer state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mclk_cnt <= '0;
            mclk     <= 1'b0;
        end else if (mclk_cnt == CW'(CLK_DIV - 1)) begin
            mclk_cnt <= '0;
            mclk     <= ~mclk;
        end else begin
            mclk_cnt <= mclk_cnt + CW'(1);
        end
    end

    // DRDY synchronizer; idles high so release never fakes a falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drdy_meta <= 1'b1;
            drdy_sync <= 1'b1;
            drdy_prev <= 1'b1;
        end else begin
            drdy_meta <= i_ads1278_drdy_n;
            drdy_sync <= drdy_meta;
            drdy_prev <= drdy_sync;
        end
    end

    assign drdy_fall  = drdy_prev & ~drdy_sync;
    assign phase_wrap = (phase == PW'(SCLK_DIV - 1));
    // No new rising edge once the last channel has been captured.
    assign sclk_rise  = (state == S_SHIFT) & phase_wrap & ~sclk & ~tail;
    assign sync_last  = (sync_cnt == SW'(SYNC_LEN - 1));
    assign word_last  = (bit_cnt == BW'(DATA_W - 1));
    assign ch_last    = (ch_cnt == IW'(NUM_CH - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (sync_last) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (drdy_fall) begin
                    state_nxt = S_SHIFT;
                end else if (!i_start) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                // Leave once sclk is (or is about to be) low after the
                // last word, so the final high phase keeps its full width.
                if (tail && (!sclk || phase_wrap)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = i_start ? S_WAIT : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_cnt     <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
            ch_cnt       <= '0;
            shreg        <= '0;
            word_rdy     <= 1'b0;
            tail         <= 1'b0;
            sclk         <= 1'b0;
            sync_n       <= 1'b1;
            o_ch_data    <= '0;
            o_ch_idx     <= '0;
            o_ch_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_ch_valid   <= 1'b0;
            o_frame_done <= (state_nxt == S_DONE);
            sync_n       <= (state_nxt != S_SYNC);
            unique case (state)
                S_SYNC: begin
                    sync_cnt  <= sync_last ? '0 : sync_cnt + SW'(1);
                    o_overrun <= 1'b0;
                end
                S_WAIT: begin
                    phase    <= '0;
                    bit_cnt  <= '0;
                    ch_cnt   <= '0;
                    word_rdy <= 1'b0;
                    tail     <= 1'b0;
                    sclk     <= 1'b0;
                end
                S_SHIFT: begin
                    if (drdy_fall) begin
                        o_overrun <= 1'b1;
                    end
                    phase <= phase_wrap ? '0 : phase + PW'(1);
                    if (phase_wrap) begin
                        sclk <= tail ? 1'b0 : ~sclk;
                    end
                    word_rdy <= 1'b0;
                    if (sclk_rise) begin
                        shreg <= {shreg[DATA_W-2:0], i_ads1278_dout};
                        if (word_last) begin
                            bit_cnt  <= '0;
                            word_rdy <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    // Word is published the cycle after its last sample.
                    if (word_rdy) begin
                        o_ch_data  <= shreg;
                        o_ch_idx   <= ch_cnt;
                        o_ch_valid <= 1'b1;
                        ch_cnt     <= ch_cnt + IW'(1);
                        if (ch_last) begin
                            tail <= 1'b1;
                        end
                    end
                end
                default: begin
                    sync_cnt <= '0;
                    phase    <= '0;
                    word_rdy <= 1'b0;
                    tail     <= 1'b0;
                    sclk     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ads1278_frame_reader.sv
// Bench for ads1278_frame_reader: DOUT model on sclk, scoreboard of
// expected channel words, table of frame scenarios plus hand sequences.
module tb_ads1278_frame_reader;

    localparam int NCH  = 8;
    localparam int WCYC = 96;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_ads1278_drdy_n = 1'b1;
    logic        i_ads1278_dout;
    logic        o_ads1278_clk;
    logic        o_ads1278_sclk;
    logic        o_ads1278_sync_n;
    logic [23:0] o_ch_data;
    logic [2:0]  o_ch_idx;
    logic        o_ch_valid;
    logic        o_frame_done;
    logic        o_busy;
    logic        o_overrun;

    ads1278_frame_reader dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .i_start          (i_start),
        .i_ads1278_drdy_n (i_ads1278_drdy_n),
        .i_ads1278_dout   (i_ads1278_dout),
        .o_ads1278_clk    (o_ads1278_clk),
        .o_ads1278_sclk   (o_ads1278_sclk),
        .o_ads1278_sync_n (o_ads1278_sync_n),
        .o_ch_data        (o_ch_data),
        .o_ch_idx         (o_ch_idx),
        .o_ch_valid       (o_ch_valid),
        .o_frame_done     (o_frame_done),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // ADC model: next bit presented after each sclk falling edge.
    logic        model_clr = 1'b0;
    int          bitpos = 0;
    logic [23:0] salt = 24'h0;

    always @(negedge o_ads1278_sclk or posedge model_clr) begin
        if (model_clr) bitpos <= 0;
        else bitpos <= bitpos + 1;
    end

    function automatic logic dout_bit(input int p, input logic [23:0] s);
        int k;
        int b;
        logic [23:0] w;
        k = p / 24;
        b = 23 - (p % 24);
        if (k >= NCH) return 1'b0;
        w = (24'hA50000 + 24'(k)) ^ s;
        return w[b];
    endfunction

    assign i_ads1278_dout = dout_bit(bitpos, salt);

    typedef struct {
        logic [2:0]  idx;
        logic [23:0] data;
    } exp_t;

    typedef struct {
        logic [23:0] salt;
        int          stop_after;
        int          ovr_at;
        logic        exp_ovr;
    } row_t;

    exp_t sb[$];
    row_t tbl[5];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_valid = 0;
    int   done_cyc = 0;
    int   rises = 0;
    logic prev_sclk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge sys_clk);
        cyc++;
        if (o_ads1278_sclk && !prev_sclk) rises++;
        prev_sclk = o_ads1278_sclk;
        if (o_ch_valid) begin
            chk("valid_done_overlap", 64'(o_frame_done), 64'(0));
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got idx=%0d data=%h want none",
                         o_ch_idx, o_ch_data);
            end else begin
                e = sb.pop_front();
                chk("ch_idx", 64'(o_ch_idx), 64'(e.idx));
                chk("ch_data", 64'(o_ch_data), 64'(e.data));
                if (e.idx != 3'd0)
                    chk("strobe_spacing", 64'(cyc - last_valid), 64'(WCYC));
                last_valid = cyc;
            end
        end
        if (o_frame_done) done_cyc = cyc;
    endtask

    task automatic chk_reset(input string name);
        chk(name,
            {o_ads1278_sclk, o_ads1278_sync_n, o_busy, o_ch_valid,
             o_frame_done, o_overrun, o_ads1278_clk, o_ch_idx, o_ch_data},
            {7'b0100000, 3'd0, 24'd0});
    endtask

    task automatic push_frame(input logic [23:0] s);
        salt = s;
        for (int k = 0; k < NCH; k++)
            sb.push_back(exp_t'{3'(k), (24'hA50000 + 24'(k)) ^ s});
        model_clr = 1'b1;
        #1;
        model_clr = 1'b0;
    endtask

    task automatic run_frame(input row_t r);
        int  t;
        int  drdy_cyc;
        bit  seen;
        if (!o_busy) begin
            i_start = 1'b1;
            repeat (6) step();
            chk("overrun_cleared_by_sync", 64'(o_overrun), 64'(0));
            chk("busy_in_wait", 64'(o_busy), 64'(1));
        end
        push_frame(r.salt);
        i_ads1278_drdy_n = 1'b0;
        drdy_cyc = cyc;
        rises = 0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 2000) begin
            step();
            t++;
            if (r.ovr_at > 0 && t == r.ovr_at + 3) i_ads1278_drdy_n = 1'b1;
            if (r.ovr_at > 0 && t == r.ovr_at + 7) i_ads1278_drdy_n = 1'b0;
            if (o_ch_valid && r.stop_after >= 0 &&
                int'(o_ch_idx) == r.stop_after)
                i_start = 1'b0;
            if (o_frame_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout got no frame_done want one");
        end else begin
            chk("frame_len", 64'(done_cyc - drdy_cyc), 64'(771));
            chk("done_after_last", 64'(done_cyc - last_valid), 64'(1));
            chk("all_words_seen", 64'(sb.size()), 64'(0));
            chk("sclk_rises", 64'(rises), 64'(NCH * 24));
            chk("overrun", 64'(o_overrun), 64'(r.exp_ovr));
        end
        sb.delete();
        i_ads1278_drdy_n = 1'b1;
        if (r.stop_after >= 0) begin
            step();
            chk("busy_after_stop", 64'(o_busy), 64'(0));
            rises = 0;
            repeat (40) step();
            chk("no_sclk_after_stop", 64'(rises), 64'(0));
            chk("still_idle", 64'(o_busy), 64'(0));
        end else begin
            repeat (4) step();
        end
    endtask

    initial begin
        logic exp_sync[6];
        bit   any_sclk;
        bit   any_sync;
        bit   any_busy;
        logic prev_mclk;
        int   r1;
        int   r2;
        int   lows;
        int   t;
        bit   seen;

        tbl[0] = '{24'h000000, -1, 0, 1'b0};
        tbl[1] = '{24'h5A5A5A, -1, 200, 1'b1};
        tbl[2] = '{24'h0F0F0F, 3, 0, 1'b1};
        tbl[3] = '{24'hFFFFFF, -1, 0, 1'b0};
        tbl[4] = '{24'h123456, 7, 0, 1'b0};
        exp_sync = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset and idle.
        #12;
        chk_reset("reset_hold");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        any_sclk = 0;
        any_sync = 0;
        any_busy = 0;
        prev_mclk = o_ads1278_clk;
        r1 = -1;
        r2 = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_ads1278_sclk) any_sclk = 1;
            if (!o_ads1278_sync_n) any_sync = 1;
            if (o_busy) any_busy = 1;
            if (o_ads1278_clk && !prev_mclk) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev_mclk = o_ads1278_clk;
        end
        chk("idle_sclk", 64'(any_sclk), 64'(0));
        chk("idle_sync_low", 64'(any_sync), 64'(0));
        chk("idle_busy", 64'(any_busy), 64'(0));
        chk("mclk_period", 64'(r2 - r1), 64'(4));

        // SYNC pulse.
        i_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            chk("sync_n_seq", 64'(o_ads1278_sync_n), 64'(exp_sync[i]));
        end
        chk("busy_after_sync", 64'(o_busy), 64'(1));

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Reset in the middle of channel 2.
        i_start = 1'b1;
        repeat (6) step();
        push_frame(24'h000000);
        i_ads1278_drdy_n = 1'b0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 1000) begin
            step();
            t++;
            if (o_ch_valid && o_ch_idx == 3'd1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL midframe_timeout got no ch1 strobe want one");
        end
        repeat (20) step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset("reset_midframe");
        sb.delete();
        i_ads1278_drdy_n = 1'b1;
        repeat (3) step();
        chk_reset("reset_midframe_hold");
        sys_rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0)
                chk("restart_sync_first", 64'(o_ads1278_sync_n), 64'(0));
            if (!o_ads1278_sync_n) lows++;
        end
        chk("restart_sync_len", 64'(lows), 64'(4));
        chk("restart_busy", 64'(o_busy), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
